complex_ram_mp: RTL and testbench
=================================

Name: complex_ram_mp

Overview:
- Clocked multi-read-port complex-sample RAM for FFT/butterfly datapaths.
- Replaces the single-size, combinationally written 2R1W complex memory with a parametrised successor. Adds:
  - clocked write with enable;
  - selectable read latency and write-first bypass;
  - out-of-range address protection;
  - a hardware clear sequencer, so every location reads zero after reset.
- Sits between the stage controller (which issues addresses) and the butterfly units (which consume samples).

Parameters:
- DATA_W, 16, width of each real and imaginary component; a complex word is 2*DATA_W bits, {re, im}, re in the upper half.
- DEPTH, 32, number of complex words; need not be a power of two.
- A_LEN, 5, address width; must satisfy 2**A_LEN >= DEPTH.
- RD_PORTS, 2, number of independent read ports, 1..8.
- READ_LAT, 1, read latency: 0 = combinational, 1 = registered.
- BYPASS, 1, write-first forwarding when READ_LAT=1; ignored when READ_LAT=0.

Ports:
- clk  in  1  sole clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  one-cycle request to zero the whole memory.
- busy  out  1  high while the clear sequencer runs.
- we  in  1  write enable.
- waddr  in  A_LEN  write address.
- wdata  in  2*DATA_W  write data, {re, im}.
- raddr  in  RD_PORTS*A_LEN  flattened read addresses; port k occupies bits [k*A_LEN +: A_LEN].
- rdata  out  RD_PORTS*2*DATA_W  flattened read data; port k occupies bits [k*2*DATA_W +: 2*DATA_W].

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset:
  - busy=1 in the cycle after rst is sampled.
  - Clear counter = 0.
  - Registered rdata (READ_LAT=1) = 0.
  - rst has priority over every other input.
- Clear FSM, states IDLE and CLEAR:
  - rst → CLEAR.
  - IDLE with clr=1 → CLEAR.
  - In CLEAR, one location per cycle is written to 0, counter 0..DEPTH-1. On the cycle writing DEPTH-1 → IDLE.
  - busy = (state==CLEAR); a full clear takes exactly DEPTH cycles.
  - clr sampled while in CLEAR: ignored, no restart.
  - rst during CLEAR: restarts the sweep from address 0.
- Writes:
  - mem[waddr] <= wdata on the rising edge when we=1, busy=0 and waddr < DEPTH.
  - Writes during busy are dropped; no queueing.
  - Writes with waddr >= DEPTH are dropped.
- Reads, READ_LAT=0:
  - rdata_k = mem[raddr_k] combinationally.
  - A same-cycle write to the same address is visible only after the edge (read-old).
- Reads, READ_LAT=1:
  - rdata_k is registered and updates every cycle; latency 1.
  - BYPASS=1: if we is accepted and waddr == raddr_k, rdata_k <= wdata (write-first).
  - BYPASS=0: the old contents are returned (read-old).
- Out-of-range reads: raddr_k >= DEPTH returns 0 on that port only; other ports are unaffected.
- Reads during busy: return the current contents (partially cleared); no stall. Consumers must wait for busy=0.
- Any number of ports may read the same address in the same cycle.
- Arithmetic: no arithmetic is performed on data; words are stored and returned bit-exact. Only the clear counter counts, A_LEN bits wide, and it never wraps past DEPTH-1.

Decomposition:
- Shared macro/package file:
  - complex word width (2*DATA_W);
  - re/im slice helpers;
  - the FSM state encodings IDLE=1'b0 and CLEAR=1'b1.
- Sub-module complex_ram_clear_seq: the counter, the FSM and busy; it outputs the clear write enable and address.
- Top level: the storage array, write muxing between clear and user writes, and a generate loop over RD_PORTS read ports with optional output register and bypass.

Test Plan:
- Reset, DEPTH=32, READ_LAT=1: pulse rst → busy=1 for exactly 32 cycles. Then all 32 addresses on both ports read 0 one cycle after being addressed.
- Write then read: write 0x0003_FFFD at address 5, then raddr0=5 and raddr1=6 → next cycle rdata0=0x0003_FFFD, rdata1=0.
- Collision, BYPASS=1: write 0x1234_5678 to address 9 while raddr0=9 (old value 0) → rdata0=0x1234_5678 one cycle later. Same stimulus with BYPASS=0 → rdata0=0.
- Clear during traffic: fill addresses 0..31 with nonzero data, then pulse clr.
  - we pulses during busy are dropped.
  - A second clr at cycle 10 of the sweep is ignored.
  - busy falls after 32 cycles and all locations read 0.
- rst at cycle 12 of a clear → sweep restarts; busy stays high for a further 32 cycles from the rst edge.
- DEPTH=20, A_LEN=5: write to address 25 is dropped; raddr=25 → 0; address 19 writes and reads normally. Repeat with RD_PORTS=4 and READ_LAT=0, checking same-cycle combinational reads.

Source files
------------

// File: rtl/complex_ram_mp_pkg.sv
// Shared definitions for the multi-read-port complex sample RAM:
// complex word width, re/im slice helpers and the clear FSM states.
package complex_ram_mp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CPLX_W_DEF = 2 * DATA_W_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // A complex word carries {re, im}, so it is twice the component width.
    function automatic int cplxWidth(input int dataW);
        return 2 * dataW;
    endfunction

    // The real part lives in the upper half of the word.
    function automatic logic [DATA_W_DEF-1:0] cplxRe(input logic [CPLX_W_DEF-1:0] w);
        return w[CPLX_W_DEF-1 -: DATA_W_DEF];
    endfunction

    // The imaginary part lives in the lower half of the word.
    function automatic logic [DATA_W_DEF-1:0] cplxIm(input logic [CPLX_W_DEF-1:0] w);
        return w[DATA_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/complex_ram_clear_seq.sv
// Clear sequencer: sweeps every location to zero, one per cycle, after
// reset or on a clear request, and reports busy while doing so.
module complex_ram_clear_seq
    import complex_ram_mp_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int A_LEN = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             clrWe_o,
    output logic [A_LEN-1:0] clrAddr_o
);

    localparam logic [A_LEN-1:0] LAST_ADDR = A_LEN'(DEPTH - 1);

    clr_state_e       state_q, state_d;
    logic [A_LEN-1:0] cnt_q, cnt_d;

    // State and sweep counter; reset always (re)starts a sweep from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a clear request during a sweep is ignored, and the
    // counter returns to 0 after the last location instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + A_LEN'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o    = (state_q == CLEAR);
    assign clrWe_o   = (state_q == CLEAR);
    assign clrAddr_o = cnt_q;

endmodule

// File: rtl/complex_ram_mp.sv
// Multi-read-port complex sample RAM with clocked write, optional
// registered reads with write-first bypass, range protection and a
// hardware clear sweep.
module complex_ram_mp
    import complex_ram_mp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 32,
    parameter int A_LEN    = 5,
    parameter int RD_PORTS = 2,
    parameter int READ_LAT = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    output logic                         busy,
    input  logic                         we,
    input  logic [A_LEN-1:0]             waddr,
    input  logic [2*DATA_W-1:0]          wdata,
    input  logic [RD_PORTS*A_LEN-1:0]    raddr,
    output logic [RD_PORTS*2*DATA_W-1:0] rdata
);

    localparam int CW = cplxWidth(DATA_W);

    logic [CW-1:0]    mem [DEPTH];
    logic             clrWe;
    logic [A_LEN-1:0] clrAddr;
    logic             userWe;

    complex_ram_clear_seq #(
        .DEPTH (DEPTH),
        .A_LEN (A_LEN)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .busy_o    (busy),
        .clrWe_o   (clrWe),
        .clrAddr_o (clrAddr)
    );

    // A user write is taken only when idle, out of reset and in range.
    assign userWe = we && !busy && !rst && (32'(waddr) < 32'(DEPTH));

    // Storage: the clear sweep owns the write port while it runs.
    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem[clrAddr] <= '0;
        end else if (userWe) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [A_LEN-1:0] ra;
        logic [CW-1:0]    word;

        assign ra   = raddr[k*A_LEN +: A_LEN];
        assign word = (32'(ra) < 32'(DEPTH)) ? mem[ra] : '0;

        if (READ_LAT == 0) begin : g_comb
            assign rdata[k*CW +: CW] = word;
        end else begin : g_reg
            logic [CW-1:0] rdWord_q, rdWord_d;

            // Forward the incoming write when it hits this port's address.
            always_comb begin
                rdWord_d = word;
                if ((BYPASS != 0) && userWe && (waddr == ra)) begin
                    rdWord_d = wdata;
                end
            end

            // Registered read data, cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdWord_q <= '0;
                end else begin
                    rdWord_q <= rdWord_d;
                end
            end

            assign rdata[k*CW +: CW] = rdWord_q;
        end
    end

endmodule

// File: tb/tb_complex_ram_mp.sv
// Bench for complex_ram_mp: two registered-read instances (bypass on/off)
// sharing stimulus, plus a DEPTH=20, four-port combinational instance.
module tb_complex_ram_mp;

    logic clk = 1'b0;
    int   cyc = 0;

    // Free-running clock and cycle counter used to tag expectations.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstA, clrA, weA;
    logic [4:0]  waddrA;
    logic [31:0] wdataA;
    logic [9:0]  raddrA;
    logic [63:0] rdataA, rdataC;
    logic        busyA, busyC;

    logic         rstB, clrB, weB;
    logic [4:0]   waddrB;
    logic [31:0]  wdataB;
    logic [19:0]  raddrB;
    logic [127:0] rdataB;
    logic         busyB;

    complex_ram_mp #(.DATA_W(16), .DEPTH(32), .A_LEN(5), .RD_PORTS(2), .READ_LAT(1), .BYPASS(1)) dutA (
        .clk(clk), .rst(rstA), .clr(clrA), .busy(busyA), .we(weA),
        .waddr(waddrA), .wdata(wdataA), .raddr(raddrA), .rdata(rdataA)
    );

    complex_ram_mp #(.DATA_W(16), .DEPTH(32), .A_LEN(5), .RD_PORTS(2), .READ_LAT(1), .BYPASS(0)) dutC (
        .clk(clk), .rst(rstA), .clr(clrA), .busy(busyC), .we(weA),
        .waddr(waddrA), .wdata(wdataA), .raddr(raddrA), .rdata(rdataC)
    );

    complex_ram_mp #(.DATA_W(16), .DEPTH(20), .A_LEN(5), .RD_PORTS(4), .READ_LAT(0), .BYPASS(1)) dutB (
        .clk(clk), .rst(rstB), .clr(clrB), .busy(busyB), .we(weB),
        .waddr(waddrB), .wdata(wdataB), .raddr(raddrB), .rdata(rdataB)
    );

    typedef struct {
        int          cyc;
        int          dut;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t  qA[$];
    exp_t  qB[$];
    string nA[$];
    string nB[$];
    int    compared   = 0;
    int    mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] portWord(input logic [127:0] bus, input int p);
        return bus[p*32 +: 32];
    endfunction

    task automatic expectA(input int dut, input int port, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.port = port; e.exp = v;
        qA.push_back(e);
        nA.push_back(name);
    endtask

    task automatic expectB(input int port, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc; e.dut = 2; e.port = port; e.exp = v;
        qB.push_back(e);
        nB.push_back(name);
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1);
        @(posedge clk);
        #1;
        rstA = r; clrA = c; weA = w; waddrA = wa; wdataA = wd; raddrA = {r1, r0};
    endtask

    task automatic applyStimulusB(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                  input logic [4:0] r0, input logic [4:0] r1,
                                  input logic [4:0] r2, input logic [4:0] r3);
        @(posedge clk);
        #1;
        weB = w; waddrB = wa; wdataB = wd; raddrB = {r3, r2, r1, r0};
    endtask

    // Counts busy cycles starting at a falling edge, bounded.
    task automatic countBusy(input int which, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (which == 0 ? !busyA : !busyB) break;
            n++;
            @(negedge clk);
        end
    endtask

    // Monitor: registered instances answer one cycle after the read is
    // issued, the combinational instance answers in the same cycle.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        while (qA.size() > 0 && qA[0].cyc == cyc - 1) begin
            e = qA.pop_front();
            n = nA.pop_front();
            checkOutput(n, portWord(e.dut == 0 ? {64'b0, rdataA} : {64'b0, rdataC}, e.port), e.exp);
        end
        while (qB.size() > 0 && qB[0].cyc == cyc) begin
            e = qB.pop_front();
            n = nB.pop_front();
            checkOutput(n, portWord(rdataB, e.port), e.exp);
        end
    end

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        rstA = 1'b1; clrA = 1'b0; weA = 1'b0; waddrA = '0; wdataA = '0; raddrA = '0;
        rstB = 1'b1; clrB = 1'b0; weB = 1'b0; waddrB = '0; wdataB = '0; raddrB = '0;

        // Reset: registered outputs zero, busy for exactly DEPTH cycles.
        @(posedge clk);
        #1 rstA = 1'b0;
        @(negedge clk);
        checkOutput("reset rdata0", rdataA[31:0], 32'h0);
        checkOutput("reset rdata1", rdataA[63:32], 32'h0);
        countBusy(0, n);
        checkOutput("reset busy cycles", 32'(n), 32'd32);

        // Every location reads zero after the reset sweep.
        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            expectA(0, 0, 32'h0, $sformatf("post-reset rd p0 a%0d", a));
            expectA(0, 1, 32'h0, $sformatf("post-reset rd p1 a%0d", 31 - a));
        end

        // Write then read.
        applyStimulus(0, 0, 1, 5'd5, 32'h0003_FFFD, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 5'd5, 5'd6);
        expectA(0, 0, 32'h0003_FFFD, "wr/rd p0 a5");
        expectA(0, 1, 32'h0, "wr/rd p1 a6");

        // Collision: write-first with bypass, read-old without.
        applyStimulus(0, 0, 1, 5'd9, 32'h1234_5678, 5'd9, 5'd0);
        expectA(0, 0, 32'h1234_5678, "bypass p0 a9");
        expectA(1, 0, 32'h0, "no-bypass p0 a9");
        expectA(0, 1, 32'h0, "collision p1 a0");
        applyStimulus(0, 0, 0, 0, 0, 5'd9, 5'd5);
        expectA(0, 0, 32'h1234_5678, "after collision p0 a9");
        expectA(1, 0, 32'h1234_5678, "after collision nb p0 a9");
        expectA(0, 1, 32'h0003_FFFD, "after collision p1 a5");

        // Fill with nonzero data and spot-check.
        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 0, 1, 5'(a), {16'(a + 1), 16'hBEEF}, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 5'd31, 5'd0);
        expectA(0, 0, {16'd32, 16'hBEEF}, "fill rd p0 a31");
        expectA(0, 1, {16'd1, 16'hBEEF}, "fill rd p1 a0");

        // Clear during traffic: writes dropped, second clr ignored.
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(0, (i == 10), 1, 5'd0, 32'hFFFF_0000 | 32'(i), 0, 0);
            @(negedge clk);
            if (!busyA) begin
                weA = 1'b0;
                clrA = 1'b0;
                break;
            end
            n++;
        end
        checkOutput("clr busy cycles", 32'(n), 32'd32);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 5'(a), 5'(a));
            expectA(0, 0, 32'h0, $sformatf("post-clr rd p0 a%0d", a));
            expectA(0, 1, 32'h0, $sformatf("post-clr rd p1 a%0d", a));
        end

        // Reset in the middle of a clear restarts the sweep.
        applyStimulus(0, 0, 1, 5'd7, 32'h5555_AAAA, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus((i == 11), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (!busyA) break;
            n++;
        end
        checkOutput("rst mid-clear busy cycles", 32'(n), 32'd44);
        applyStimulus(0, 0, 0, 0, 0, 5'd7, 5'd31);
        expectA(0, 0, 32'h0, "post-rst rd p0 a7");
        expectA(0, 1, 32'h0, "post-rst rd p1 a31");

        // DEPTH=20, four combinational ports.
        @(posedge clk);
        #1 rstB = 1'b0;
        @(negedge clk);
        countBusy(1, n);
        checkOutput("B busy cycles", 32'(n), 32'd20);

        applyStimulusB(1, 5'd25, 32'hDEAD_BEEF, 5'd25, 5'd19, 5'd0, 5'd25);
        expectB(0, 32'h0, "B oor rd p0 a25");
        expectB(1, 32'h0, "B rd p1 a19");
        expectB(2, 32'h0, "B rd p2 a0");
        expectB(3, 32'h0, "B oor rd p3 a25");

        applyStimulusB(1, 5'd19, 32'hCAFE_0001, 5'd25, 5'd19, 5'd19, 5'd0);
        expectB(0, 32'h0, "B oor after wr p0 a25");
        expectB(1, 32'h0, "B read-old p1 a19");
        expectB(2, 32'h0, "B read-old p2 a19");
        expectB(3, 32'h0, "B rd p3 a0");

        applyStimulusB(1, 5'd0, 32'h0000_0007, 5'd19, 5'd25, 5'd19, 5'd0);
        expectB(0, 32'hCAFE_0001, "B rd p0 a19");
        expectB(1, 32'h0, "B oor p1 a25");
        expectB(2, 32'hCAFE_0001, "B rd p2 a19");
        expectB(3, 32'h0, "B read-old p3 a0");

        applyStimulusB(0, 5'd0, 32'h0, 5'd0, 5'd25, 5'd24, 5'd19);
        expectB(0, 32'h0000_0007, "B rd p0 a0");
        expectB(1, 32'h0, "B oor p1 a25");
        expectB(2, 32'h0, "B oor p2 a24");
        expectB(3, 32'hCAFE_0001, "B rd p3 a19");

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("pending expectations", 32'(qA.size() + qB.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
